hilo_muldiv: RTL and testbench

//  Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers for the MIPS pipeline EX stage.

---
 rtl/hilo_muldiv.sv | 183 ++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// One iteration per cycle (shift-add multiply, restoring divide), then a sign-fix
// cycle that writes HI/LO and pulses done. Divide by zero skips the iterations.
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_r;
    logic               is_div_r;
    logic               div_zero_r;
    logic               sign_q_r;
    logic               sign_rem_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   opd_r;       // multiplicand or divisor magnitude
    logic [WIDTH:0]     acc_hi_r;    // product upper half / partial remainder
    logic [WIDTH-1:0]   acc_lo_r;    // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic               busy_r;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [WIDTH:0]     next_hi_s;
    logic [WIDTH-1:0]   next_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;

    // Two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand, honouring signedness.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? neg_w(x) : x;
    endfunction

    // Operand signs and magnitudes; op[0]==0 selects the signed variants.
    always_comb begin
        sign_a_s = rs_data[WIDTH-1] & ~op[0];
        sign_b_s = rt_data[WIDTH-1] & ~op[0];
        mag_a_s  = mag_w(rs_data, sign_a_s);
        mag_b_s  = mag_w(rt_data, sign_b_s);
    end

    // One multiply or divide iteration, plus the sign-corrected final results.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r[WIDTH-1:0]}
                    + (acc_lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_hi_r[WIDTH-1:0], acc_lo_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opd_r});
        if (is_div_r) begin
            next_hi_s = div_ge_s ? (div_shift_s - {1'b0, opd_r}) : div_shift_s;
            next_lo_s = {acc_lo_r[WIDTH-2:0], div_ge_s};
        end else begin
            next_hi_s = {1'b0, mul_sum_s[WIDTH:1]};
            next_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end

        prod_s = {acc_hi_r[WIDTH-1:0], acc_lo_r};
        if (sign_q_r && !is_div_r) begin
            prod_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            prod_s = prod_s;
        end

        if (div_zero_r) begin
            fix_hi_s = acc_hi_r[WIDTH-1:0];
            fix_lo_s = acc_lo_r;
        end else if (is_div_r) begin
            fix_hi_s = sign_rem_r ? neg_w(acc_hi_r[WIDTH-1:0]) : acc_hi_r[WIDTH-1:0];
            fix_lo_s = sign_q_r ? neg_w(acc_lo_r) : acc_lo_r;
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM with datapath registers and registered HI/LO/busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            is_div_r   <= 1'b0;
            div_zero_r <= 1'b0;
            sign_q_r   <= 1'b0;
            sign_rem_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            opd_r      <= {WIDTH{1'b0}};
            acc_hi_r   <= {(WIDTH+1){1'b0}};
            acc_lo_r   <= {WIDTH{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r     <= 1'b1;
                        is_div_r   <= op[1];
                        sign_q_r   <= sign_a_s ^ sign_b_s;
                        sign_rem_r <= sign_a_s;
                        cnt_r      <= {CNT_W{1'b0}};
                        if (op[1] && (rt_data == {WIDTH{1'b0}})) begin
                            div_zero_r <= 1'b1;
                            acc_hi_r   <= {1'b0, rs_data};
                            acc_lo_r   <= {WIDTH{1'b1}};
                            state_r    <= FIX;
                        end else begin
                            div_zero_r <= 1'b0;
                            acc_hi_r   <= {(WIDTH+1){1'b0}};
                            opd_r      <= op[1] ? mag_b_s : mag_a_s;
                            acc_lo_r   <= op[1] ? mag_a_s : mag_b_s;
                            state_r    <= RUN;
                        end
                    end else begin
                        if (mthi) begin
                            hi_r <= rs_data;
                        end
                        if (mtlo) begin
                            lo_r <= rs_data;
                        end
                    end
                end
                RUN: begin
                    acc_hi_r <= next_hi_s;
                    acc_lo_r <= next_lo_s;
                    cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(WIDTH-1)) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed vector table, hand-written corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS semantics from plain 64-bit arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
            2'b10: begin
                if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin eh = a % b; el = a / b; end
            end
        endcase
    endtask

    function automatic int lat(input logic [1:0] o, input logic [31:0] b);
        return (o[1] && b == 32'd0) ? 1 : 33;
    endfunction

    // Issue one operation and check latency, busy, results and the done pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        int busy_cyc;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'b00; rs_data = $urandom; rt_data = $urandom;
        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat(o, b)));
        chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(lat(o, b)));
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
        chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] eh, el, a, b;
        logic [1:0]  o;

        tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        tbl[4] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        tbl[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        tbl[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        tbl[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

        reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = 32'd0; rt_data = 32'd0;
        mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo);
        end

        // MTHI alone, then MTHI+MTLO together, no done pulse.
        mthi = 1'b1; rs_data = 32'h0000_1234;
        @(posedge clk); #1;
        mthi = 1'b0;
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
        chk("mthi_no_done", {63'd0, done}, 64'd0);
        mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo_both", {hi, lo}, 64'hCAFEF00D_CAFEF00D);

        // start together with mthi: start wins, HI untouched until completion.
        start = 1'b1; mthi = 1'b1; op = 2'b11; rs_data = 32'd9; rt_data = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        chk("start_wins_hi", {32'd0, hi}, 64'hCAFEF00D);
        chk("start_wins_busy", {63'd0, busy}, 64'd1);
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
        end
        chk("start_wins_res", {hi, lo}, {32'd1, 32'd2});
        @(posedge clk); #1;

        // start/mthi/op changes held during RUN are ignored.
        start = 1'b1; op = 2'b01; rs_data = 32'd6; rt_data = 32'd7;
        @(posedge clk); #1;
        op = 2'b10; rs_data = 32'h5555_5555; rt_data = 32'd3; mthi = 1'b1; mtlo = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("run_ignore_hilo", {hi, lo}, {32'd1, 32'd2});
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("run_ignore_done", {63'd0, done}, 64'd1);
        chk("run_ignore_res", {hi, lo}, {32'd0, 32'd42});
        @(posedge clk); #1;

        // Reset in the middle of a MULT aborts it.
        start = 1'b1; op = 2'b00; rs_data = 32'd1000; rt_data = 32'd1000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_hilo", {hi, lo}, 64'd0);
        chk("midreset_busy_done", {62'd0, busy, done}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("midreset_no_late_result", {hi, lo}, 64'd0);
        run_op("after_reset", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Randomised operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            model(o, a, b, eh, el);
            run_op($sformatf("rnd%0d", i), o, a, b, eh, el);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
